// File: rtl/operand_fetch.sv
// Register-read / issue stage of the 16-bit RISC pipeline.
// Drives the register-file read ports, bypasses same-cycle writeback data,
// tracks outstanding destination writes in a per-register busy scoreboard and
// hands resolved operands to execute through a one-entry output register.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both high. valid never depends combinationally on ready. Once valid is
// raised, the payload stays stable until the transfer. in_ready is also
// computed when in_valid is low. out_valid comes straight from a flop.
module operand_fetch #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int CTRL_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  // upstream decoded instruction
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_W-1:0]        in_rs1,
  input  logic [ADDR_W-1:0]        in_rs2,
  input  logic [ADDR_W-1:0]        in_rd,
  input  logic                     in_wr,
  input  logic [DATA_W-1:0]        in_imm,
  input  logic [CTRL_W-1:0]        in_ctrl,
  // register-file read ports
  output logic [ADDR_W-1:0]        rf_read_addr_1,
  output logic [ADDR_W-1:0]        rf_read_addr_2,
  input  logic [DATA_W-1:0]        rf_read_data_1,
  input  logic [DATA_W-1:0]        rf_read_data_2,
  // writeback bus (same signals as the register-file write port)
  input  logic                     wb_en,
  input  logic [ADDR_W-1:0]        wb_dest,
  input  logic [DATA_W-1:0]        wb_data,
  // execute-stage operand bundle
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_op1,
  output logic [DATA_W-1:0]        out_op2,
  output logic [ADDR_W-1:0]        out_rd,
  output logic                     out_wr,
  output logic [DATA_W-1:0]        out_imm,
  output logic [CTRL_W-1:0]        out_ctrl,
  // scoreboard state, bit i = write to register i outstanding
  output logic [(1<<ADDR_W)-1:0]   busy_mask
);

  localparam int NREG = 1 << ADDR_W;

  logic              wb_hit_1;
  logic              wb_hit_2;
  logic              wb_hit_d;
  logic              src1_ok;
  logic              src2_ok;
  logic              dst_ok;
  logic              out_free;
  logic              accept;
  logic [DATA_W-1:0] src1_data;
  logic [DATA_W-1:0] src2_data;
  logic [NREG-1:0]   set_vec;
  logic [NREG-1:0]   clr_vec;
  logic [NREG-1:0]   busy_next;

  assign rf_read_addr_1 = in_rs1;
  assign rf_read_addr_2 = in_rs2;

  // Hazard checks and writeback bypass. The register file commits wb_data on
  // the same edge that captures the operands, so a match must be forwarded.
  always_comb begin
    wb_hit_1  = wb_en && (wb_dest == in_rs1);
    wb_hit_2  = wb_en && (wb_dest == in_rs2);
    wb_hit_d  = wb_en && (wb_dest == in_rd);
    src1_data = wb_hit_1 ? wb_data : rf_read_data_1;
    src2_data = wb_hit_2 ? wb_data : rf_read_data_2;
    src1_ok   = !busy_mask[in_rs1] || wb_hit_1;
    src2_ok   = !busy_mask[in_rs2] || wb_hit_2;
    dst_ok    = !in_wr || !busy_mask[in_rd] || wb_hit_d;
    out_free  = !out_valid || out_ready;
    in_ready  = out_free && src1_ok && src2_ok && dst_ok;
    accept    = in_valid && in_ready;
  end

  // Scoreboard next state: a new destination claim wins over a same-index writeback.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (accept && in_wr) set_vec = NREG'(1) << in_rd;
    if (wb_en)           clr_vec = NREG'(1) << wb_dest;
    busy_next = (busy_mask & ~clr_vec) | set_vec;
  end

  // Scoreboard register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy_mask <= '0;
    else       busy_mask <= busy_next;
  end

  // One-entry output register: load on accept, drain when execute takes it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_op1   <= '0;
      out_op2   <= '0;
      out_rd    <= '0;
      out_wr    <= 1'b0;
      out_imm   <= '0;
      out_ctrl  <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_op1   <= src1_data;
      out_op2   <= src2_data;
      out_rd    <= in_rd;
      out_wr    <= in_wr;
      out_imm   <= in_imm;
      out_ctrl  <= in_ctrl;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: a behavioural register file, a per-cycle vector
// table with expected in_ready / busy_mask, an expected-bundle queue for the
// output side, and hand-written reset sequences.
module tb_operand_fetch;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int CTRL_W = 8;
  localparam int BW     = 2*DATA_W + ADDR_W + 1 + DATA_W + CTRL_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_rs1, in_rs2, in_rd;
  logic              in_wr;
  logic [DATA_W-1:0] in_imm;
  logic [CTRL_W-1:0] in_ctrl;
  logic [ADDR_W-1:0] rf_read_addr_1, rf_read_addr_2;
  logic [DATA_W-1:0] rf_read_data_1, rf_read_data_2;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_dest;
  logic [DATA_W-1:0] wb_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_op1, out_op2;
  logic [ADDR_W-1:0] out_rd;
  logic              out_wr;
  logic [DATA_W-1:0] out_imm;
  logic [CTRL_W-1:0] out_ctrl;
  logic [7:0]        busy_mask;

  operand_fetch #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CTRL_W(CTRL_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_wr(in_wr),
    .in_imm(in_imm), .in_ctrl(in_ctrl),
    .rf_read_addr_1(rf_read_addr_1), .rf_read_addr_2(rf_read_addr_2),
    .rf_read_data_1(rf_read_data_1), .rf_read_data_2(rf_read_data_2),
    .wb_en(wb_en), .wb_dest(wb_dest), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op1(out_op1), .out_op2(out_op2), .out_rd(out_rd), .out_wr(out_wr),
    .out_imm(out_imm), .out_ctrl(out_ctrl),
    .busy_mask(busy_mask)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // Behavioural register file: preset during reset, written by the writeback bus.
  logic [DATA_W-1:0] rf [8];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) rf[i] <= DATA_W'(16'h1000 + i * 16'h0101);
      rf[1] <= 16'h1234;
      rf[2] <= 16'h00FF;
    end else if (wb_en) begin
      rf[wb_dest] <= wb_data;
    end
  end
  assign rf_read_data_1 = rf[rf_read_addr_1];
  assign rf_read_data_2 = rf[rf_read_addr_2];

  // ---------------- scoreboard ----------------
  logic [BW-1:0] exp_q[$];
  logic          m_out_valid;
  int            n_checks;
  int            n_fail;

  task automatic check(input string name, input int step_no, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (step %0d): got 0x%0h, expected 0x%0h", name, step_no, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic              v;
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    logic [ADDR_W-1:0] rd;
    logic              wr;
    logic [DATA_W-1:0] imm;
    logic              wbe;
    logic [ADDR_W-1:0] wbd;
    logic [DATA_W-1:0] wbdata;
    logic              ordy;
    logic              exp_rdy;   // expected in_ready this cycle
    logic [7:0]        exp_busy;  // expected busy_mask this cycle (before the edge)
  } vec_t;

  vec_t tbl [22];

  function automatic vec_t mk(input logic v, input int rs1, input int rs2, input int rd,
                              input logic wr, input int imm, input logic wbe, input int wbd,
                              input int wbdata, input logic ordy, input logic exp_rdy,
                              input int exp_busy);
    vec_t r;
    r.v = v; r.rs1 = ADDR_W'(rs1); r.rs2 = ADDR_W'(rs2); r.rd = ADDR_W'(rd); r.wr = wr;
    r.imm = DATA_W'(imm); r.wbe = wbe; r.wbd = ADDR_W'(wbd); r.wbdata = DATA_W'(wbdata);
    r.ordy = ordy; r.exp_rdy = exp_rdy; r.exp_busy = 8'(exp_busy);
    return r;
  endfunction

  // ---------------- driver ----------------
  // Called just after a falling edge; drives one cycle and checks it.
  task automatic step(input vec_t r, input int idx);
    logic [DATA_W-1:0] e1, e2;
    logic [BW-1:0]     exp_b;
    logic [CTRL_W-1:0] ctrl;
    ctrl      = CTRL_W'($urandom_range(0, 255));
    in_valid  = r.v;   in_rs1 = r.rs1; in_rs2 = r.rs2; in_rd = r.rd; in_wr = r.wr;
    in_imm    = r.imm; in_ctrl = ctrl;
    wb_en     = r.wbe; wb_dest = r.wbd; wb_data = r.wbdata;
    out_ready = r.ordy;
    #1;
    check("in_ready",  idx, 64'(in_ready),  64'(r.exp_rdy));
    check("busy_mask", idx, 64'(busy_mask), 64'(r.exp_busy));
    check("rf_addr",   idx, {58'd0, rf_read_addr_1, rf_read_addr_2}, {58'd0, r.rs1, r.rs2});
    check("out_valid", idx, 64'(out_valid), 64'(m_out_valid));
    if (m_out_valid) begin
      if (exp_q.size() == 0) begin
        check("bundle_queue", idx, 64'd0, 64'd1);
      end else begin
        check("out_bundle", idx, 64'({out_op1, out_op2, out_rd, out_wr, out_imm, out_ctrl}), 64'(exp_q[0]));
        if (r.ordy) void'(exp_q.pop_front());
      end
    end
    if (r.v && r.exp_rdy) begin
      e1 = (r.wbe && r.wbd == r.rs1) ? r.wbdata : rf[r.rs1];
      e2 = (r.wbe && r.wbd == r.rs2) ? r.wbdata : rf[r.rs2];
      exp_b = {e1, e2, r.rd, r.wr, r.imm, ctrl};
      exp_q.push_back(exp_b);
      m_out_valid = 1'b1;
    end else if (r.ordy) begin
      m_out_valid = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset_values(input int idx);
    check("rst_out_valid", idx, 64'(out_valid), 64'd0);
    check("rst_busy",      idx, 64'(busy_mask), 64'd0);
    check("rst_bundle",    idx, 64'({out_op1, out_op2, out_rd, out_wr, out_imm, out_ctrl}), 64'd0);
  endtask

  // ---------------- test ----------------
  initial begin
    //           v  rs1 rs2 rd wr imm     wbe wbd data     ordy rdy busy
    tbl[0]  = mk(1, 1, 2, 3, 1, 'h0007, 0, 0, 0,       1, 1, 'h00); // simple issue
    tbl[1]  = mk(1, 3, 0, 6, 0, 'h0008, 0, 0, 0,       1, 0, 'h08); // RAW on r3
    tbl[2]  = mk(1, 3, 0, 6, 0, 'h0008, 0, 0, 0,       1, 0, 'h08);
    tbl[3]  = mk(1, 3, 0, 6, 0, 'h0008, 0, 0, 0,       1, 0, 'h08);
    tbl[4]  = mk(1, 3, 0, 6, 0, 'h0008, 1, 3, 'hBEEF, 1, 1, 'h08); // resolved by wb
    tbl[5]  = mk(1, 0, 1, 5, 1, 'h0009, 0, 0, 0,       1, 1, 'h00); // claim r5
    tbl[6]  = mk(1, 2, 2, 5, 1, 'h000A, 1, 5, 'h5555, 1, 1, 'h20); // set/clear collision
    tbl[7]  = mk(1, 1, 2, 4, 1, 'h000B, 0, 0, 0,       0, 0, 'h20); // backpressure
    tbl[8]  = mk(1, 1, 2, 4, 1, 'h000B, 0, 0, 0,       0, 0, 'h20);
    tbl[9]  = mk(1, 1, 2, 4, 1, 'h000B, 0, 0, 0,       0, 0, 'h20);
    tbl[10] = mk(1, 1, 2, 4, 1, 'h000B, 0, 0, 0,       0, 0, 'h20);
    tbl[11] = mk(1, 1, 2, 4, 1, 'h000B, 0, 0, 0,       1, 1, 'h20); // no-bubble transfer
    tbl[12] = mk(1, 0, 1, 4, 1, 'h000C, 0, 0, 0,       1, 0, 'h30); // WAW on r4
    tbl[13] = mk(1, 0, 1, 4, 1, 'h000C, 0, 0, 0,       1, 0, 'h30);
    tbl[14] = mk(1, 0, 1, 4, 1, 'h000C, 1, 4, 'h4444, 1, 1, 'h30);
    tbl[15] = mk(0, 0, 0, 0, 0, 'h0000, 1, 5, 'h5A5A, 1, 1, 'h30); // idle wb clears r5
    tbl[16] = mk(1, 2, 2, 1, 0, 'h000D, 1, 2, 'h2222, 1, 1, 'h10); // wb to free reg, bypass
    tbl[17] = mk(1, 0, 0, 0, 1, 'h000E, 0, 0, 0,       1, 1, 'h10); // r0 is ordinary
    tbl[18] = mk(1, 7, 0, 2, 0, 'h000F, 0, 0, 0,       1, 0, 'h11); // RAW on r0
    tbl[19] = mk(0, 0, 0, 0, 0, 'h0000, 1, 0, 'h0A0A, 1, 1, 'h11);
    tbl[20] = mk(0, 0, 0, 0, 0, 'h0000, 0, 0, 0,       1, 1, 'h10);
    tbl[21] = mk(1, 0, 1, 3, 1, 'h0010, 0, 0, 0,       0, 1, 'h10); // leaves 0x18, valid

    n_checks = 0; n_fail = 0; m_out_valid = 1'b0;
    reset = 1'b1; in_valid = 1'b0; in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_wr = 1'b0;
    in_imm = '0; in_ctrl = '0; wb_en = 1'b0; wb_dest = '0; wb_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_reset_values(-1);
    @(negedge clk);

    for (int i = 0; i < 22; i++) step(tbl[i], i);

    // Asynchronous reset between edges with a held bundle and busy r3/r4.
    out_ready = 1'b0; in_valid = 1'b0; wb_en = 1'b0;
    #1;
    check("pre_rst_busy",  100, 64'(busy_mask), 64'h18);
    check("pre_rst_valid", 100, 64'(out_valid), 64'd1);
    #1;
    reset = 1'b1;
    #1;
    check_reset_values(101);
    exp_q.delete();
    m_out_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Post-reset issue: nothing remembered, operands from the register file.
    step(mk(1, 1, 2, 3, 1, 'h0007, 0, 0, 0, 1, 1, 'h00), 200);
    step(mk(0, 0, 0, 0, 0, 'h0000, 0, 0, 0, 1, 1, 'h08), 201);
    step(mk(0, 0, 0, 0, 0, 'h0000, 1, 3, 'h0303, 1, 1, 'h08), 202);
    step(mk(0, 0, 0, 0, 0, 'h0000, 0, 0, 0, 1, 1, 'h00), 203);
    check("queue_drained", 300, 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
